// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_M0, BUSY_M1)
//   grant_e     : identity of the most recently served master (round-robin pointer)
//   WDG_W       : watchdog counter width, wide enough for the largest TIMEOUT (1024)
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_M0 = 2'd1,
    ST_BUSY_M1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_e;

  localparam int unsigned WDG_W = $clog2(1024) + 1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Watchdog for a single slave transfer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : hold the count at zero (asserted while no transfer is in flight)
//   enable_i    : count one more cycle spent waiting for the slave
//   expired_o   : high in the waiting cycle whose count equals TIMEOUT-1
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WDG_W-1:0] LIMIT = WDG_W'(TIMEOUT - 1);

  logic [WDG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only meaningful while waiting; the owner leaves BUSY in this cycle,
  // so the counter never runs past LIMIT.
  assign expired_o = enable_i & (cnt_q == LIMIT);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single memory controller.
// Master 0 is instruction fetch, master 1 is data access. Contention is
// resolved round-robin; a watchdog aborts transfers the slave never acks.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i/addr_i/data_i  : master N request
//   mN_ack_o, mN_err_o                 : master N acknowledge / timeout error
//   m_data_o                           : slave read data broadcast to both masters
//   s_cyc_o/stb_o/we_o/addr_o/data_o   : slave request
//   s_data_i, s_ack_i                  : slave read data / acknowledge
//
// Handshake: a master requests with cyc&stb and must hold its request until
// it sees ack or err (or it abandons the cycle by dropping cyc). The slave
// request is held until s_ack_i; a transfer ends on the edge after ack/err,
// and the arbiter always spends at least one IDLE cycle between transfers.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m_data_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);

  arb_state_e state_q, state_d;
  grant_e     last_q, last_d;

  logic req0, req1;
  logic busy0, busy1, busy;
  logic wdg_expired;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Gating with rst_n makes the slave cycle drop in the same instant reset
  // asserts, independent of how the flops' async clear is implemented.
  assign busy0 = rst_n & (state_q == ST_BUSY_M0);
  assign busy1 = rst_n & (state_q == ST_BUSY_M1);
  assign busy  = busy0 | busy1;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (~busy),
    .enable_i  (busy & ~s_ack_i),
    .expired_o (wdg_expired)
  );

  // Priority while busy: abandoned cycle, then ack, then timeout.
  // Ack beats timeout because the watchdog is disabled whenever s_ack_i is high.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = (last_q == GNT_M0) ? ST_BUSY_M1 : ST_BUSY_M0;
        end else if (req0) begin
          state_d = ST_BUSY_M0;
        end else if (req1) begin
          state_d = ST_BUSY_M1;
        end
      end
      ST_BUSY_M0: begin
        if (!m0_cyc_i) begin
          state_d = ST_IDLE;
        end else if (s_ack_i || wdg_expired) begin
          state_d = ST_IDLE;
          last_d  = GNT_M0;
        end
      end
      ST_BUSY_M1: begin
        if (!m1_cyc_i) begin
          state_d = ST_IDLE;
        end else if (s_ack_i || wdg_expired) begin
          state_d = ST_IDLE;
          last_d  = GNT_M1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset leaves M1 as the last grant so M0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc_o  = busy;
    s_stb_o  = busy;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    if (busy0) begin
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
    end else if (busy1) begin
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
    end
  end

  assign m0_ack_o = busy0 & s_ack_i;
  assign m1_ack_o = busy1 & s_ack_i;
  // An abandoned cycle gets no error even if it coincides with the timeout.
  assign m0_err_o = busy0 & m0_cyc_i & wdg_expired;
  assign m1_err_o = busy1 & m1_cyc_i & wdg_expired;

  assign m_data_o = s_data_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;

  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [1:0]  mc, ms, mw;
  logic [31:0] ma[2];
  logic [31:0] md[2];
  logic        s_ack;
  logic [31:0] s_dat;

  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m_data_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;

  wb_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_cyc_i  (mc[0]),
    .m0_stb_i  (ms[0]),
    .m0_we_i   (mw[0]),
    .m0_addr_i (ma[0]),
    .m0_data_i (md[0]),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_cyc_i  (mc[1]),
    .m1_stb_i  (ms[1]),
    .m1_we_i   (mw[1]),
    .m1_addr_i (ma[1]),
    .m1_data_i (md[1]),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .m_data_o  (m_data_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_data_i  (s_dat),
    .s_ack_i   (s_ack)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 none, else master index; blen: BUSY cycles so far incl. current;
  // last: master most recently completed (ack or timeout).
  int owner = -1;
  int blen  = 0;
  int last  = 1;
  logic [1:0] exp_done;

  task automatic model_reset();
    owner = -1;
    blen  = 0;
    last  = 1;
  endtask

  // Settle, then compare every output against the model's prediction.
  task automatic check_outputs();
    logic [1:0]  e_ack, e_err;
    logic        e_cyc, e_we;
    logic [31:0] e_addr, e_data;
    #1;
    e_ack = '0; e_err = '0; e_cyc = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
    if (owner >= 0) begin
      e_cyc  = 1'b1;
      e_we   = mw[owner];
      e_addr = ma[owner];
      e_data = md[owner];
      e_ack[owner] = s_ack;
      e_err[owner] = (blen == TO) && !s_ack && mc[owner];
    end
    exp_done = e_ack | e_err;
    check("s_cyc",  32'(s_cyc_o),  32'(e_cyc));
    check("s_stb",  32'(s_stb_o),  32'(e_cyc));
    check("s_we",   32'(s_we_o),   32'(e_we));
    check("s_addr", s_addr_o,      e_addr);
    check("s_data", s_data_o,      e_data);
    check("m0_ack", 32'(m0_ack_o), 32'(e_ack[0]));
    check("m1_ack", 32'(m1_ack_o), 32'(e_ack[1]));
    check("m0_err", 32'(m0_err_o), 32'(e_err[0]));
    check("m1_err", 32'(m1_err_o), 32'(e_err[1]));
    check("m_data", m_data_o,      s_dat);
  endtask

  // Apply the arbitration rules to the inputs present at the clock edge.
  task automatic advance();
    logic r0, r1;
    r0 = mc[0] & ms[0];
    r1 = mc[1] & ms[1];
    if (owner < 0) begin
      blen = 1;
      if (r0 && r1) owner = (last == 0) ? 1 : 0;
      else if (r0)  owner = 0;
      else if (r1)  owner = 1;
    end else if (!mc[owner]) begin
      owner = -1;
    end else if (s_ack || blen == TO) begin
      last  = owner;
      owner = -1;
    end else begin
      blen++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    advance();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m(input int n, input logic cyc, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    mc[n] = cyc;
    ms[n] = cyc;
    mw[n] = we;
    ma[n] = addr;
    md[n] = data;
  endtask

  logic [1:0] act;

  task automatic drive_random(input int ack_pct);
    for (int n = 0; n < 2; n++) begin
      if (act[n]) begin
        if (exp_done[n]) act[n] = 1'b0;
        else if ($urandom_range(99) < 3) act[n] = 1'b0;
      end
      if (!act[n] && $urandom_range(99) < 40) begin
        act[n] = 1'b1;
        mw[n]  = 1'($urandom_range(1));
        ma[n]  = $urandom;
        md[n]  = $urandom;
      end
      if (act[n]) begin
        mc[n] = 1'b1;
        ms[n] = 1'b1;
      end else begin
        mc[n] = ($urandom_range(9) == 0);
        ms[n] = 1'b0;
      end
    end
    s_ack = ($urandom_range(99) < ack_pct);
    s_dat = $urandom;
  endtask

  // ---------------- stimulus ----------------
  int err_at;
  int seq[$];

  initial begin
    rst_n = 1'b0;
    mc = '0; ms = '0; mw = '0;
    ma[0] = '0; ma[1] = '0; md[0] = '0; md[1] = '0;
    s_ack = 1'b0;
    s_dat = 32'h0BAD_F00D;
    act = '0;
    exp_done = '0;
    model_reset();

    // Reset state, with a stray ack that must be ignored.
    repeat (3) @(posedge clk);
    #1;
    s_ack = 1'b1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Lone m0 read, slave acks two cycles after the strobe.
    s_ack = 1'b0;
    s_dat = 32'hDEAD_BEEF;
    set_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check_outputs();
    check("r036_stb_idle", 32'(s_stb_o), 32'd0);
    tick();
    check_outputs();
    check("r036_stb_lat1", 32'(s_stb_o), 32'd1);
    tick();
    check_outputs();
    tick();
    s_ack = 1'b1;
    check_outputs();
    check("r036_ack",  32'(m0_ack_o), 32'd1);
    check("r036_data", m_data_o,      32'hDEAD_BEEF);
    check("r036_m1ack", 32'(m1_ack_o), 32'd0);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    check_outputs();
    tick();

    // m1 write, slave never acks: error on the 8th BUSY cycle.
    set_m(1, 1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678);
    err_at = -1;
    for (int i = 1; i <= 20; i++) begin
      check_outputs();
      if (i == err_at + 1 && err_at > 0) begin
        check("r038_cyc_after", 32'(s_cyc_o), 32'd0);
        check("r038_err_pulse", 32'(m1_err_o), 32'd0);
        tick();
        break;
      end
      if (m1_err_o && err_at < 0) err_at = i;
      tick();
      if (err_at > 0) set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("r038_err_cycle", 32'(err_at), 32'd9);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_outputs();
    tick();

    // Ack coincident with the timeout cycle wins.
    set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      s_ack = (i == 9);
      check_outputs();
      if (i == 9) begin
        check("r039_ack", 32'(m0_ack_o), 32'd1);
        check("r039_err", 32'(m0_err_o), 32'd0);
      end
      tick();
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    check_outputs();
    tick();

    // Reset in the middle of a BUSY_M1 transfer.
    set_m(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
    check_outputs();
    tick();
    check_outputs();
    tick();
    s_ack = 1'b1;
    #1;
    check("r040_pre_cyc", 32'(s_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("r040_cyc",  32'(s_cyc_o),  32'd0);
    check("r040_stb",  32'(s_stb_o),  32'd0);
    check("r040_ack1", 32'(m1_ack_o), 32'd0);
    check("r040_err1", 32'(m1_err_o), 32'd0);
    check("r040_ack0", 32'(m0_ack_o), 32'd0);
    model_reset();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Continuous contention with immediate acks: M0, M1, M0, M1.
    set_m(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    set_m(1, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_0001);
    s_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_outputs();
      if (m0_ack_o) seq.push_back(0);
      if (m1_ack_o) seq.push_back(1);
      tick();
    end
    check("r037_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("r037_gnt%0d", i),
            (i < seq.size()) ? 32'(seq[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    end
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ack = 1'b0;
    check_outputs();
    tick();

    // Randomized traffic: mixed acks, no acks (timeouts), always-ack.
    act = '0;
    exp_done = '0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 600; c++) begin
        drive_random((p == 0) ? 50 : (p == 1) ? 0 : 100);
        check_outputs();
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
